// File: rtl/ctrl_pkg.sv
// Shared control encodings for the CPU datapath sequencer: FSM state codes,
// address/PC mux selects, instruction format and addressing-mode constants.
// Also consumed by mux_mab, mux_pc and instr_dec.
package ctrl_pkg;

  // Sequencer state encodings (4-bit; codes 10..15 are unreachable)
  localparam logic [3:0] ST_RST     = 4'd0;
  localparam logic [3:0] ST_FETCH   = 4'd1;
  localparam logic [3:0] ST_DECODE  = 4'd2;
  localparam logic [3:0] ST_SRC_EXT = 4'd3;
  localparam logic [3:0] ST_SRC_RD  = 4'd4;
  localparam logic [3:0] ST_DST_EXT = 4'd5;
  localparam logic [3:0] ST_DST_RD  = 4'd6;
  localparam logic [3:0] ST_EXEC    = 4'd7;
  localparam logic [3:0] ST_WB_MEM  = 4'd8;
  localparam logic [3:0] ST_JMP     = 4'd9;

  // Memory address bus source select
  localparam logic [2:0] MAB_SEL_PC   = 3'd0;
  localparam logic [2:0] MAB_SEL_SOUT = 3'd1;
  localparam logic [2:0] MAB_SEL_DOUT = 3'd2;
  localparam logic [2:0] MAB_SEL_CALC = 3'd3;
  localparam logic [2:0] MAB_SEL_SP   = 3'd4;

  // Next-PC source select
  localparam logic [2:0] MPC_HOLD    = 3'd0;
  localparam logic [2:0] MPC_INC     = 3'd1;
  localparam logic [2:0] MPC_CALC    = 3'd2;
  localparam logic [2:0] MPC_RST_VEC = 3'd3;

  // Instruction formats from instr_dec
  localparam logic [1:0] FMT_DUAL    = 2'b00;
  localparam logic [1:0] FMT_SINGLE  = 2'b01;
  localparam logic [1:0] FMT_JUMP    = 2'b10;
  localparam logic [1:0] FMT_ILLEGAL = 2'b11;

  // Source (As) and destination (Ad) addressing modes
  localparam logic [1:0] AS_REG = 2'b00;
  localparam logic [1:0] AS_IDX = 2'b01;
  localparam logic [1:0] AS_IND = 2'b10;
  localparam logic [1:0] AS_INC = 2'b11;
  localparam logic       AD_REG = 1'b0;
  localparam logic       AD_IDX = 1'b1;

  // Mode bits captured in DECODE and used by the later operand/write steps
  typedef struct packed {
    logic       ad;
    logic [1:0] as_m;
    logic [1:0] fmt;
    logic       imm;
  } mode_t;

  // Autoincrement through the PC (As=11, SA=0) is the immediate mode
  function automatic logic is_imm(input logic [1:0] as_m, input logic [3:0] sa);
    return (as_m == AS_INC) && (sa == 4'd0);
  endfunction

endpackage

// File: rtl/exec_sequencer_ret_counter.sv
// Retired-instruction counter: W-bit, synchronous clear, count enable,
// wraps modulo 2^W.
module ret_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Clear has priority over increment; otherwise hold
  always_ff @(posedge clk) begin
    if (clr) begin
      count_r <= {W{1'b0}};
    end else if (en) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM for the CPU datapath. Walks each instruction through
// fetch, decode, operand extension/memory reads, execute and writeback, drives
// the MAB/PC selects and write strobes, and counts retired instructions.
module exec_sequencer
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [1:0]       FORMAT,
  input  logic [2:0]       AdAs,
  input  logic [3:0]       reg_SA,
  input  logic             cond_true,
  output logic [2:0]       MAB_SEL,
  output logic [2:0]       MPC,
  output logic             ir_ld,
  output logic             op_ld,
  output logic             op_sel,
  output logic             RW_en,
  output logic             MW_en,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  logic [3:0] state_r;
  logic [3:0] next_state_s;
  mode_t      mode_r;
  mode_t      mode_s;
  logic       inc_s;
  logic [2:0] mab_sel_s;
  logic [2:0] mpc_s;
  logic       ir_ld_s;
  logic       op_ld_s;
  logic       op_sel_s;
  logic       rw_en_s;
  logic       mw_en_s;

  // After the source operand: fetch a destination operand only for dual-op
  // instructions with an indexed destination
  function automatic logic [3:0] dest_step(input mode_t m);
    if ((m.fmt == FMT_DUAL) && (m.ad == AD_IDX)) begin
      return ST_DST_EXT;
    end else begin
      return ST_EXEC;
    end
  endfunction

  // Register writeback in EXEC when the result goes to a register
  function automatic logic exec_to_reg(input mode_t m);
    return (m.ad == AD_REG) || ((m.fmt == FMT_SINGLE) && (m.as_m == AS_REG));
  endfunction

  // Live decoder fields, captured into mode_r while in DECODE
  always_comb begin
    mode_s      = '{ad: 1'b0, as_m: 2'b00, fmt: 2'b00, imm: 1'b0};
    mode_s.ad   = AdAs[2];
    mode_s.as_m = AdAs[1:0];
    mode_s.fmt  = FORMAT;
    mode_s.imm  = is_imm(AdAs[1:0], reg_SA);
  end

  // Next-state logic; unreachable encodings fall back to RST
  always_comb begin
    next_state_s = ST_RST;
    case (state_r)
      ST_RST:   next_state_s = ST_FETCH;
      ST_FETCH: next_state_s = ST_DECODE;
      ST_DECODE: begin
        if (mode_s.fmt == FMT_JUMP) begin
          next_state_s = ST_JMP;
        end else if (mode_s.fmt == FMT_ILLEGAL) begin
          next_state_s = ST_FETCH;
        end else if ((mode_s.as_m == AS_IDX) || mode_s.imm) begin
          next_state_s = ST_SRC_EXT;
        end else if ((mode_s.as_m == AS_IND) || (mode_s.as_m == AS_INC)) begin
          next_state_s = ST_SRC_RD;
        end else begin
          next_state_s = dest_step(mode_s);
        end
      end
      ST_SRC_EXT: begin
        if (mode_r.imm) begin
          next_state_s = dest_step(mode_r);
        end else begin
          next_state_s = ST_SRC_RD;
        end
      end
      ST_SRC_RD:  next_state_s = dest_step(mode_r);
      ST_DST_EXT: next_state_s = ST_DST_RD;
      ST_DST_RD:  next_state_s = ST_EXEC;
      ST_EXEC: begin
        if (exec_to_reg(mode_r)) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_WB_MEM;
        end
      end
      ST_WB_MEM: next_state_s = ST_FETCH;
      ST_JMP:    next_state_s = ST_FETCH;
      default:   next_state_s = ST_RST;
    endcase
  end

  // State register: reset wins over stall, stall freezes the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RST;
    end else if (stall) begin
      state_r <= state_r;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Mode latch: captured on the DECODE step, held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r <= '{ad: 1'b0, as_m: 2'b00, fmt: 2'b00, imm: 1'b0};
    end else if (!stall && (state_r == ST_DECODE)) begin
      mode_r <= mode_s;
    end else begin
      mode_r <= mode_r;
    end
  end

  // Retire on every entry into FETCH except the one leaving RST
  always_comb begin
    inc_s = 1'b0;
    if (!stall && (next_state_s == ST_FETCH) && (state_r != ST_RST)) begin
      inc_s = 1'b1;
    end else begin
      inc_s = 1'b0;
    end
  end

  ret_counter #(.W(CNT_W)) u_ret_counter (
    .clk   (clk),
    .clr   (rst),
    .en    (inc_s),
    .count (retired)
  );

  // Moore output decode from the state register and latched modes
  always_comb begin
    mab_sel_s = MAB_SEL_PC;
    mpc_s     = MPC_HOLD;
    ir_ld_s   = 1'b0;
    op_ld_s   = 1'b0;
    op_sel_s  = 1'b0;
    rw_en_s   = 1'b0;
    mw_en_s   = 1'b0;
    case (state_r)
      ST_RST: mpc_s = MPC_RST_VEC;
      ST_FETCH: begin
        mab_sel_s = MAB_SEL_PC;
        ir_ld_s   = 1'b1;
        mpc_s     = MPC_INC;
      end
      ST_SRC_EXT: begin
        mab_sel_s = MAB_SEL_PC;
        mpc_s     = MPC_INC;
        op_ld_s   = mode_r.imm;
      end
      ST_SRC_RD: begin
        mab_sel_s = (mode_r.as_m == AS_IDX) ? MAB_SEL_CALC : MAB_SEL_SOUT;
        op_ld_s   = 1'b1;
        rw_en_s   = (mode_r.as_m == AS_INC) && !mode_r.imm;
      end
      ST_DST_EXT: begin
        mab_sel_s = MAB_SEL_PC;
        mpc_s     = MPC_INC;
      end
      ST_DST_RD: begin
        mab_sel_s = MAB_SEL_CALC;
        op_ld_s   = 1'b1;
        op_sel_s  = 1'b1;
      end
      ST_EXEC:   rw_en_s = exec_to_reg(mode_r);
      ST_WB_MEM: begin
        mab_sel_s = MAB_SEL_CALC;
        mw_en_s   = 1'b1;
      end
      ST_JMP:  mpc_s = cond_true ? MPC_CALC : MPC_HOLD;
      default: mpc_s = MPC_HOLD;
    endcase
  end

  // Strobes are suppressed while memory is not ready; selects follow state
  assign MAB_SEL = mab_sel_s;
  assign MPC     = mpc_s;
  assign ir_ld   = ir_ld_s & ~stall;
  assign op_ld   = op_ld_s & ~stall;
  assign op_sel  = op_sel_s;
  assign RW_en   = rw_en_s & ~stall;
  assign MW_en   = mw_en_s & ~stall;
  assign state   = state_r;

endmodule
